// File: rtl/fetch_sequencer_pkg.sv
// Shared SAP-II fetch definitions: opcode values, FSM state encoding and
// instruction-length encoding used by the fetch sequencer and its decoder.
package fetch_sequencer_pkg;

    // Opcodes that the fetch path needs to recognise.
    localparam logic [7:0] OpHlt  = 8'h76;
    localparam logic [7:0] OpJmp  = 8'hC3;
    localparam logic [7:0] OpJnz  = 8'hC2;
    localparam logic [7:0] OpJz   = 8'hCA;
    localparam logic [7:0] OpJm   = 8'hFA;
    localparam logic [7:0] OpLda  = 8'h3A;
    localparam logic [7:0] OpSta  = 8'h32;
    localparam logic [7:0] OpCall = 8'hCD;
    localparam logic [7:0] OpMviA = 8'h3E;
    localparam logic [7:0] OpMviB = 8'h06;
    localparam logic [7:0] OpMviC = 8'h0E;
    localparam logic [7:0] OpAni  = 8'hE6;
    localparam logic [7:0] OpOri  = 8'hF6;
    localparam logic [7:0] OpXri  = 8'hEE;

    // Instruction lengths in bytes, encoded in two bits.
    localparam logic [1:0] Len1 = 2'd1;
    localparam logic [1:0] Len2 = 2'd2;
    localparam logic [1:0] Len3 = 2'd3;

    // Fetch FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StInc,
        StMem,
        StDispatch,
        StJump,
        StExec,
        StHalt
    } state_e;

endpackage

// File: rtl/fetch_sequencer_instr_length_decoder.sv
// Combinational opcode classifier: byte length of the instruction and whether
// it is one of the jump opcodes that may reload the program counter.
module fetch_sequencer_instr_length_decoder
    import fetch_sequencer_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic [1:0] len_o,
    output logic       is_jump_o
);

    // Length lookup: three-byte address ops, two-byte immediates, rest single byte.
    always_comb begin
        len_o = Len1;
        unique case (opcode_i)
            OpJmp, OpJnz, OpJz, OpJm, OpLda, OpSta, OpCall: len_o = Len3;
            OpMviA, OpMviB, OpMviC, OpAni, OpOri, OpXri:    len_o = Len2;
            default:                                        len_o = Len1;
        endcase
    end

    // Jump classification; the unconditional JMP is still a jump here.
    always_comb begin
        is_jump_o = 1'b0;
        unique case (opcode_i)
            OpJmp, OpJnz, OpJz, OpJm: is_jump_o = 1'b1;
            default:                  is_jump_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// SAP-II fetch-cycle controller. Steps the program counter and MAR over WBUS,
// latches opcode and little-endian operand bytes, resolves jumps locally and
// hands every other instruction to the execute controller.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              RUN,
    inout  wire  [ADDR_W-1:0] WBUS,
    input  logic              JUMP_TAKE,
    input  logic              EXEC_DONE,
    output logic              Cp,
    output logic              Ep,
    output logic              nLp,
    output logic              Lm,
    output logic              Er,
    output logic              nLi,
    output logic              Eo,
    output logic [DATA_W-1:0] OPCODE,
    output logic [ADDR_W-1:0] OPERAND,
    output logic              FETCH_DONE,
    output logic              HALTED
);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [ADDR_W-1:0] operand_q, operand_d;

    logic [DATA_W-1:0] mem_byte;
    logic [DATA_W-1:0] dec_opcode;
    logic [1:0]        dec_len;
    logic              dec_is_jump;
    logic              jump_taken;

    assign mem_byte = WBUS[DATA_W-1:0];

    // While the opcode byte is on the bus its length must be known in the same
    // cycle to decide whether more bytes follow, so decode the bus directly.
    assign dec_opcode = (state_q == StMem && idx_q == 2'd0) ? mem_byte : opcode_q;

    fetch_sequencer_instr_length_decoder u_len_dec (
        .opcode_i  (dec_opcode),
        .len_o     (dec_len),
        .is_jump_o (dec_is_jump)
    );

    // JMP is unconditional; the other jumps follow the execute-side condition.
    assign jump_taken = (opcode_q == OpJmp) || JUMP_TAKE;

    // Next-state, byte index and latch updates.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        unique case (state_q)
            StIdle: begin
                if (RUN) begin
                    state_d = StAddr;
                    idx_d   = 2'd0;
                end
            end
            StAddr: state_d = StInc;
            StInc:  state_d = StMem;
            StMem: begin
                unique case (idx_q)
                    2'd0:    opcode_d              = mem_byte;
                    2'd1:    operand_d[DATA_W-1:0] = mem_byte;
                    2'd2:    operand_d[ADDR_W-1:DATA_W] = mem_byte;
                    default: ;
                endcase
                idx_d = idx_q + 2'd1;
                if (idx_q < (dec_len - 2'd1)) begin
                    state_d = StAddr;
                end else begin
                    state_d = StDispatch;
                end
            end
            StDispatch: begin
                if (opcode_q == OpHlt) begin
                    state_d = StHalt;
                end else if (dec_is_jump && jump_taken) begin
                    state_d = StJump;
                end else if (dec_is_jump) begin
                    // PC already points past the operand; just fetch on.
                    state_d = StAddr;
                    idx_d   = 2'd0;
                end else begin
                    state_d = StExec;
                end
            end
            StJump: begin
                state_d = StAddr;
                idx_d   = 2'd0;
            end
            StExec: begin
                if (EXEC_DONE) begin
                    state_d = StAddr;
                    idx_d   = 2'd0;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // State and latch registers; CLR overrides everything, even mid-fetch.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            opcode_q  <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    // Moore control decode; only Cp in INC and nLp in JUMP touch the PC, so
    // they can never coincide, and each bus enable belongs to a single state.
    always_comb begin
        Cp         = 1'b0;
        Ep         = 1'b0;
        nLp        = 1'b1;
        Lm         = 1'b0;
        Er         = 1'b0;
        nLi        = 1'b1;
        Eo         = 1'b0;
        FETCH_DONE = 1'b0;
        HALTED     = 1'b0;
        unique case (state_q)
            StAddr: begin
                Ep = 1'b1;
                Lm = 1'b1;
            end
            StInc: Cp = 1'b1;
            StMem: begin
                Er  = 1'b1;
                nLi = (idx_q != 2'd0);
            end
            StDispatch: FETCH_DONE = (opcode_q != OpHlt) && !dec_is_jump;
            StJump: begin
                Eo  = 1'b1;
                nLp = 1'b0;
            end
            StHalt:  HALTED = 1'b1;
            default: ;
        endcase
    end

    assign OPCODE  = opcode_q;
    assign OPERAND = operand_q;
    assign WBUS    = Eo ? operand_q : {ADDR_W{1'bz}};

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: program_counter, MAR and 64 KiB memory models on
// WBUS, directed scenarios, then a random program checked against an
// instruction-level model of fetch behaviour.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        clr, run, jump_take, exec_done;
    wire  [15:0] wbus;
    logic        cp, ep, nlp, lm, er, nli, eo, fd, halted;
    logic [7:0]  opcode;
    logic [15:0] operand;

    logic [15:0] pc, mar;
    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .CLK        (clk),
        .CLR        (clr),
        .RUN        (run),
        .WBUS       (wbus),
        .JUMP_TAKE  (jump_take),
        .EXEC_DONE  (exec_done),
        .Cp         (cp),
        .Ep         (ep),
        .nLp        (nlp),
        .Lm         (lm),
        .Er         (er),
        .nLi        (nli),
        .Eo         (eo),
        .OPCODE     (opcode),
        .OPERAND    (operand),
        .FETCH_DONE (fd),
        .HALTED     (halted)
    );

    // Other bus drivers: program counter and memory.
    assign wbus = ep ? pc : (er ? {8'h00, mem[mar]} : 16'hzzzz);

    // program_counter and MAR behaviour; Cp has priority over a load.
    always @(posedge clk) begin
        if (clr) pc <= 16'h0000;
        else if (cp) pc <= pc + 16'd1;
        else if (!nlp) pc <= wbus;
        if (lm) mar <= wbus;
    end

    // Per-cycle invariants and FETCH_DONE pulse counter.
    always @(negedge clk) begin
        checks++;
        assert (!(cp && !nlp) && (int'(ep) + int'(er) + int'(eo) <= 1)) else begin
            errors++;
            $error("FAIL invariant observed cp=%b nlp=%b ep=%b er=%b eo=%b expected exclusive",
                   cp, nlp, ep, er, eo);
        end
        if (fd) fd_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cp"}, cp, 0);
        chk({tag, "_ep"}, ep, 0);
        chk({tag, "_nlp"}, nlp, 1);
        chk({tag, "_lm"}, lm, 0);
        chk({tag, "_er"}, er, 0);
        chk({tag, "_nli"}, nli, 1);
        chk({tag, "_eo"}, eo, 0);
        chk({tag, "_fd"}, fd, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_opcode"}, opcode, 8'h00);
        chk({tag, "_operand"}, operand, 16'h0000);
    endtask

    // Instruction length straight from the opcode table.
    function automatic int ref_len(input logic [7:0] op);
        logic [7:0] three [7] = '{8'hC3, 8'hC2, 8'hCA, 8'hFA, 8'h3A, 8'h32, 8'hCD};
        logic [7:0] two   [6] = '{8'h3E, 8'h06, 8'h0E, 8'hE6, 8'hF6, 8'hEE};
        foreach (three[i]) if (three[i] == op) return 3;
        foreach (two[i]) if (two[i] == op) return 2;
        return 1;
    endfunction

    function automatic bit ref_is_jump(input logic [7:0] op);
        return op == 8'hC3 || op == 8'hC2 || op == 8'hCA || op == 8'hFA;
    endfunction

    initial begin
        int          n;
        int          fd_snap;
        bit          flag;
        logic [15:0] ref_pc, ref_operand, a;
        logic [7:0]  op, pick [13];
        int          len, r;
        bit          jt, taken;

        clr = 1'b1; run = 1'b0; jump_take = 1'b0; exec_done = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        {mem[16'h0000], mem[16'h0001]} = {8'h3E, 8'h42};
        {mem[16'h0002], mem[16'h0003], mem[16'h0004]} = {8'hC3, 8'h15, 8'hAC};
        {mem[16'hAC15], mem[16'hAC16], mem[16'hAC17]} = {8'hCA, 8'h00, 8'h90};
        {mem[16'hAC18], mem[16'hAC19], mem[16'hAC1A]} = {8'hCA, 8'h00, 8'h90};
        {mem[16'h9000], mem[16'h9001], mem[16'h9002]} = {8'h3A, 8'h34, 8'h12};

        // Reset for two cycles, then idle without RUN.
        repeat (2) tick();
        clr = 1'b0;
        chk_reset("rst");
        tick();
        chk("idle_ep", ep, 0);

        // MVI A,42: 7 cycles from first ADDR to FETCH_DONE.
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("mvi_addr_ep", ep, 1);
        chk("mvi_addr_lm", lm, 1);
        chk("mvi_addr_pc", wbus, 16'h0000);
        n = 1;
        while (!fd && n < 40) begin tick(); n++; end
        chk("mvi_latency", n, 7);
        chk("mvi_opcode", opcode, 8'h3E);
        chk("mvi_operand_lo", operand[7:0], 8'h42);
        repeat (3) tick();
        chk("exec_hold_ep", ep, 0);
        chk("exec_hold_cp", cp, 0);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("after_exec_ep", ep, 1);
        chk("after_exec_pc", wbus, 16'h0002);

        // JMP AC15: JUMP state in cycle 11, drives operand with nLp low.
        n = 1;
        while (!eo && n < 40) begin tick(); n++; end
        chk("jmp_latency", n, 11);
        chk("jmp_nlp", nlp, 0);
        chk("jmp_bus", wbus, 16'hAC15);
        tick();
        chk("jmp_target_ep", ep, 1);
        chk("jmp_target_pc", wbus, 16'hAC15);

        // JZ not taken: straight back to ADDR at AC18, no JUMP, no FETCH_DONE.
        jump_take = 1'b0;
        flag = 1'b0;
        repeat (10) begin tick(); if (eo || fd) flag = 1'b1; end
        chk("jz_nt_no_jump", flag, 0);
        chk("jz_nt_ep", ep, 1);
        chk("jz_nt_pc", wbus, 16'hAC18);

        // JZ taken to 9000.
        jump_take = 1'b1;
        repeat (10) tick();
        chk("jz_t_eo", eo, 1);
        chk("jz_t_nlp", nlp, 0);
        chk("jz_t_bus", wbus, 16'h9000);
        jump_take = 1'b0;
        tick();
        chk("jz_t_pc", wbus, 16'h9000);

        // LDA aborted by CLR while reading its second byte.
        fd_snap = fd_count;
        repeat (5) tick();
        chk("lda_mem_er", er, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_reset("abort");
        repeat (12) tick();
        chk("abort_no_fd", fd_count, fd_snap);
        chk("abort_idle_ep", ep, 0);

        // HLT: halts permanently, RUN ignored, CLR releases.
        mem[16'h0000] = 8'h76;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("hlt_addr_pc", wbus, 16'h0000);
        repeat (3) tick();
        chk("hlt_no_fd", fd, 0);
        tick();
        chk("hlt_halted", halted, 1);
        run = 1'b1;
        flag = 1'b0;
        repeat (6) begin tick(); if (ep || cp) flag = 1'b1; end
        run = 1'b0;
        chk("hlt_no_pc_activity", flag, 0);
        chk("hlt_still_halted", halted, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("hlt_cleared", halted, 0);

        // Random program against an instruction-level model.
        pick = '{8'hC3, 8'hC2, 8'hCA, 8'hFA, 8'h3A, 8'h32, 8'hCD,
                 8'h3E, 8'h06, 8'h0E, 8'hE6, 8'hF6, 8'hEE};
        for (int i = 0; i < 65536; i++) begin
            r = $urandom_range(0, 99);
            if (r == 0) mem[i] = 8'h76;
            else if (r < 60) mem[i] = pick[$urandom_range(0, 12)];
            else mem[i] = 8'($urandom);
        end
        mem[16'h0000] = 8'h00;
        ref_pc = 16'h0000;
        ref_operand = 16'h0000;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int k = 0; k < 300; k++) begin
            chk("r_addr_ep", ep, 1);
            chk("r_addr_pc", wbus, ref_pc);
            op = mem[ref_pc];
            len = ref_len(op);
            a = ref_pc + 16'd1;
            if (len >= 2) ref_operand[7:0] = mem[a];
            a = ref_pc + 16'd2;
            if (len == 3) ref_operand[15:8] = mem[a];
            jt = 1'($urandom_range(0, 1));
            jump_take = jt;
            repeat (3 * len) tick();
            if (op == 8'h76) begin
                chk("r_hlt_fd", fd, 0);
                tick();
                chk("r_hlt_halted", halted, 1);
                clr = 1'b1;
                tick();
                clr = 1'b0;
                ref_pc = 16'h0000;
                ref_operand = 16'h0000;
                run = 1'b1;
                tick();
                run = 1'b0;
            end else if (ref_is_jump(op)) begin
                taken = (op == 8'hC3) || jt;
                chk("r_jmp_fd", fd, 0);
                tick();
                if (taken) begin
                    chk("r_jmp_eo", eo, 1);
                    chk("r_jmp_bus", wbus, ref_operand);
                    tick();
                    ref_pc = ref_operand;
                end else begin
                    ref_pc = ref_pc + 16'(len);
                end
            end else begin
                chk("r_fd", fd, 1);
                chk("r_opcode", opcode, op);
                chk("r_operand", operand, ref_operand);
                jump_take = 1'b0;
                tick();
                repeat ($urandom_range(0, 3)) tick();
                exec_done = 1'b1;
                tick();
                exec_done = 1'b0;
                ref_pc = ref_pc + 16'(len);
            end
            jump_take = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
